// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } dump_state_e;

    // Index width for a register count; never below one bit.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_dump_ctrl.sv
// rtl/regfile_dump_ctrl.sv - sequential dump engine streaming every register over valid/ready
module regfile_dump_ctrl
    import regfile_pkg::*;
#(
    parameter int  XLEN = XLEN_DEFAULT,
    parameter int  NREG = NREG_DEFAULT,
    localparam int AW   = addr_width(NREG)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            dump_req_i,
    input  logic            dump_ready_i,
    output logic [AW-1:0]   cap_addr_o,
    input  logic [XLEN-1:0] cap_data_i,
    output logic            dump_busy_o,
    output logic            dump_valid_o,
    output logic [AW-1:0]   dump_idx_o,
    output logic [XLEN-1:0] dump_data_o
);

    dump_state_e   state_q, state_d;
    logic [AW-1:0] idx_q;
    logic [XLEN-1:0] data_q;
    logic          last_beat;

    assign last_beat = (idx_q == AW'(NREG - 1));

    // Next state, plus the index the array is read at for the next capture.
    always_comb begin
        state_d    = state_q;
        cap_addr_o = idx_q + 1'b1;
        case (state_q)
            IDLE: begin
                cap_addr_o = '0;
                if (dump_req_i) state_d = SEND;
            end
            SEND: begin
                if (dump_ready_i && last_beat) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Beat registers: captured on start and on every accept, cleared when the dump ends.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            data_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_req_i) begin
                        idx_q  <= '0;
                        data_q <= cap_data_i;
                    end
                end
                SEND: begin
                    if (dump_ready_i) begin
                        if (last_beat) begin
                            idx_q  <= '0;
                            data_q <= '0;
                        end else begin
                            idx_q  <= cap_addr_o;
                            data_q <= cap_data_i;
                        end
                    end
                end
                default: begin
                    idx_q  <= '0;
                    data_q <= '0;
                end
            endcase
        end
    end

    assign dump_busy_o  = (state_q == SEND);
    assign dump_valid_o = (state_q == SEND);
    assign dump_idx_o   = idx_q;
    assign dump_data_o  = data_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with bypass, zero register and dump
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int  XLEN     = XLEN_DEFAULT,
    parameter int  NREG     = NREG_DEFAULT,
    parameter int  NRD      = 2,
    parameter int  NWR      = 1,
    parameter int  BYPASS   = 1,
    parameter int  ZERO_REG = 1,
    localparam int AW       = addr_width(NREG)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NRD-1:0][AW-1:0]    rd_addr_i,
    output logic [NRD-1:0][XLEN-1:0]  rd_data_o,
    input  logic [NWR-1:0]            wr_en_i,
    input  logic [NWR-1:0][AW-1:0]    wr_addr_i,
    input  logic [NWR-1:0][XLEN-1:0]  wr_data_i,
    input  logic                      dump_req_i,
    output logic                      dump_busy_o,
    output logic                      dump_valid_o,
    input  logic                      dump_ready_i,
    output logic [AW-1:0]             dump_idx_o,
    output logic [XLEN-1:0]           dump_data_o
);

    logic [XLEN-1:0] mem [NREG];
    logic [AW-1:0]   cap_addr;
    logic [XLEN-1:0] cap_data;

    // Array update; later ports overwrite earlier ones so the highest index wins.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREG; r++) mem[r] <= '0;
        end else begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en_i[p] && !((ZERO_REG != 0) && (wr_addr_i[p] == '0)))
                    mem[wr_addr_i[p]] <= wr_data_i[p];
            end
        end
    end

    // Read muxes: array value, overridden by matching writes, then forced zero for reg 0.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            rd_data_o[k] = mem[rd_addr_i[k]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en_i[p] && (wr_addr_i[p] == rd_addr_i[k]))
                        rd_data_o[k] = wr_data_i[p];
                end
            end
            if ((ZERO_REG != 0) && (rd_addr_i[k] == '0))
                rd_data_o[k] = '0;
        end
    end

    // Dump captures see the pre-edge array, never the bypass path.
    assign cap_data = ((ZERO_REG != 0) && (cap_addr == '0)) ? '0 : mem[cap_addr];

    regfile_dump_ctrl #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_dump_ctrl (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .dump_req_i   (dump_req_i),
        .dump_ready_i (dump_ready_i),
        .cap_addr_o   (cap_addr),
        .cap_data_i   (cap_data),
        .dump_busy_o  (dump_busy_o),
        .dump_valid_o (dump_valid_o),
        .dump_idx_o   (dump_idx_o),
        .dump_data_o  (dump_data_o)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 16;
    localparam int NRD  = 2;
    localparam int NWR  = 2;
    localparam int AW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_a, rd_b;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     dump_req, dump_ready;
    logic                     busy_a, valid_a, busy_b, valid_b;
    logic [AW-1:0]            idx_a, idx_b;
    logic [XLEN-1:0]          ddata_a, ddata_b;

    // dut_a: bypass on, zero register on. dut_b: bypass off, zero register off.
    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_a),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .dump_req_i(dump_req), .dump_busy_o(busy_a), .dump_valid_o(valid_a),
        .dump_ready_i(dump_ready), .dump_idx_o(idx_a), .dump_data_o(ddata_a));

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .rd_addr_i(rd_addr), .rd_data_o(rd_b),
        .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .dump_req_i(dump_req), .dump_busy_o(busy_b), .dump_valid_o(valid_b),
        .dump_ready_i(dump_ready), .dump_idx_o(idx_b), .dump_data_o(ddata_b));

    typedef struct {
        logic [1:0]             wen;
        logic [1:0][AW-1:0]     waddr;
        logic [1:0][XLEN-1:0]   wdata;
        logic [1:0][AW-1:0]     raddr;
        logic [1:0][XLEN-1:0]   exp_a;
        logic [1:0][XLEN-1:0]   exp_b;
    } vec_t;

    typedef struct {
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] data_a;
        logic [XLEN-1:0] data_b;
    } beat_t;

    vec_t            vecs[13];
    beat_t           exp_q[$];
    logic [XLEN-1:0] model_a[NREG];
    logic [XLEN-1:0] model_b[NREG];
    int              checks = 0;
    int              errors = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] wen,
                                input int wa0, input logic [XLEN-1:0] wd0,
                                input int wa1, input logic [XLEN-1:0] wd1,
                                input int ra0, input int ra1,
                                input logic [XLEN-1:0] ea0, input logic [XLEN-1:0] ea1,
                                input logic [XLEN-1:0] eb0, input logic [XLEN-1:0] eb1);
        vec_t v;
        v.wen   = wen;
        v.waddr = {AW'(wa1), AW'(wa0)};
        v.wdata = {wd1, wd0};
        v.raddr = {AW'(ra1), AW'(ra0)};
        v.exp_a = {ea1, ea0};
        v.exp_b = {eb1, eb0};
        return v;
    endfunction

    task automatic model_write(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        model_b[a] = d;
        if (a != '0) model_a[a] = d;
    endtask

    task automatic clear_models();
        for (int r = 0; r < NREG; r++) begin
            model_a[r] = '0;
            model_b[r] = '0;
        end
    endtask

    task automatic push_snapshot();
        beat_t b;
        exp_q.delete();
        for (int r = 0; r < NREG; r++) begin
            b.idx    = AW'(r);
            b.data_a = model_a[r];
            b.data_b = model_b[r];
            exp_q.push_back(b);
        end
    endtask

    task automatic read_all_zero(input string tag);
        for (int r = 0; r < NREG; r++) begin
            rd_addr = {AW'(NREG - 1 - r), AW'(r)};
            #1;
            check({tag, "_rd0_a"}, rd_a[0], '0);
            check({tag, "_rd1_a"}, rd_a[1], '0);
            check({tag, "_rd0_b"}, rd_b[0], '0);
            check({tag, "_rd1_b"}, rd_b[1], '0);
        end
    endtask

    task automatic start_dump();
        dump_req = 1'b1;
        #1;
        check("pre_start_valid", XLEN'(valid_a), '0);
        @(posedge clk); #1;
        dump_req = 1'b0;
        check("start_valid", XLEN'(valid_a), 1);
        check("start_busy", XLEN'(busy_a), 1);
        check("start_idx", XLEN'(idx_a), 0);
    endtask

    // mode 0: ready held high; 1: ready 1,0,0,1 with a stray req; 2: ready high with writes at idx 3
    task automatic run_dump(input int mode, input int max_cycles);
        int              c = 0;
        logic            held = 1'b0;
        logic [AW-1:0]   hold_idx = '0;
        logic [XLEN-1:0] hold_data = '0;
        logic [3:0]      rdy_pat = 4'b1001;
        logic            did_write;
        beat_t           b;
        while (exp_q.size() > 0 && c < max_cycles) begin
            dump_ready = (mode == 1) ? rdy_pat[c % 4] : 1'b1;
            dump_req   = (mode == 1 && c == 5);
            wr_en      = '0;
            did_write  = 1'b0;
            if (mode == 2 && valid_a && idx_a == AW'(3)) begin
                wr_en      = 2'b11;
                wr_addr    = {AW'(4), AW'(10)};
                wr_data    = {32'h0000_4444, 32'h0000_00A5};
                did_write  = 1'b1;
            end
            #1;
            check("dump_valid", XLEN'(valid_a), 1);
            check("dump_busy", XLEN'(busy_a), 1);
            if (held) begin
                check("hold_idx", XLEN'(idx_a), XLEN'(hold_idx));
                check("hold_data", ddata_a, hold_data);
            end
            if (dump_ready) begin
                b = exp_q.pop_front();
                check("beat_idx_a", XLEN'(idx_a), XLEN'(b.idx));
                check("beat_data_a", ddata_a, b.data_a);
                check("beat_idx_b", XLEN'(idx_b), XLEN'(b.idx));
                check("beat_data_b", ddata_b, b.data_b);
                held = 1'b0;
            end else begin
                held      = 1'b1;
                hold_idx  = idx_a;
                hold_data = ddata_a;
            end
            @(posedge clk); #1;
            if (did_write) begin
                model_write(0, AW'(10), 32'h0000_00A5);
                model_write(1, AW'(4), 32'h0000_4444);
            end
            c++;
        end
        dump_req   = 1'b0;
        dump_ready = 1'b0;
        wr_en      = '0;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL dump_timeout: %0d beats left, required 0", exp_q.size());
        end
        check("end_busy", XLEN'(busy_a), 0);
        check("end_valid", XLEN'(valid_a), 0);
        check("end_idx", XLEN'(idx_a), 0);
        check("end_data", ddata_a, 0);
        check("end_busy_b", XLEN'(busy_b), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        beat_t b;

        vecs[0]  = mk(2'b00, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0);
        vecs[1]  = mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 5, 0, 32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(2'b00, 0, 0, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
        vecs[3]  = mk(2'b11, 7, 32'h11, 7, 32'h22, 7, 7, 32'h22, 32'h22, 0, 0);
        vecs[4]  = mk(2'b00, 0, 0, 0, 0, 7, 5, 32'h22, 32'hDEADBEEF, 32'h22, 32'hDEADBEEF);
        vecs[5]  = mk(2'b01, 0, 32'h55, 0, 0, 0, 7, 0, 32'h22, 0, 32'h22);
        vecs[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 32'h55, 32'h55);
        vecs[7]  = mk(2'b11, 3, 32'h1234, 15, 32'hFFFFFFFF, 15, 3, 32'hFFFFFFFF, 32'h1234, 0, 0);
        vecs[8]  = mk(2'b00, 0, 0, 0, 0, 3, 15, 32'h1234, 32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF);
        vecs[9]  = mk(2'b11, 9, 32'hAB, 0, 32'h99, 0, 9, 0, 32'hAB, 32'h55, 0);
        vecs[10] = mk(2'b00, 0, 0, 0, 0, 0, 9, 0, 32'hAB, 32'h99, 32'hAB);
        vecs[11] = mk(2'b00, 9, 32'hBAD, 9, 32'hBAD, 9, 9, 32'hAB, 32'hAB, 32'hAB, 32'hAB);
        vecs[12] = mk(2'b00, 0, 0, 0, 0, 9, 3, 32'hAB, 32'h1234, 32'hAB, 32'h1234);

        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        clear_models();

        // Reset state
        #2;
        read_all_zero("reset");
        check("reset_busy", XLEN'(busy_a), 0);
        check("reset_valid", XLEN'(valid_a), 0);
        check("reset_idx", XLEN'(idx_a), 0);
        check("reset_data", ddata_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Dump of an all-zero file, full throughput
        push_snapshot();
        start_dump();
        run_dump(0, 40);

        // Read/write vectors
        for (int i = 0; i < 13; i++) begin
            wr_en   = vecs[i].wen;
            wr_addr = vecs[i].waddr;
            wr_data = vecs[i].wdata;
            rd_addr = vecs[i].raddr;
            #1;
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("vec%0d_a%0d", i, k), rd_a[k], vecs[i].exp_a[k]);
                check($sformatf("vec%0d_b%0d", i, k), rd_b[k], vecs[i].exp_b[k]);
            end
            @(posedge clk); #1;
            for (int p = 0; p < NWR; p++)
                if (vecs[i].wen[p]) model_write(p, vecs[i].waddr[p], vecs[i].wdata[p]);
        end
        wr_en = '0;

        // Backpressured dump with a stray request in the middle
        push_snapshot();
        start_dump();
        run_dump(1, 100);
        repeat (2) @(posedge clk);
        #1;
        check("no_restart", XLEN'(busy_a), 0);

        // Writes during a dump: reg 10 ahead of capture, reg 4 on its capture edge
        push_snapshot();
        b = exp_q[10]; b.data_a = 32'hA5; b.data_b = 32'hA5; exp_q[10] = b;
        start_dump();
        run_dump(2, 40);
        rd_addr = {AW'(10), AW'(4)};
        #1;
        check("after_wr4", rd_a[0], 32'h4444);
        check("after_wr10", rd_a[1], 32'hA5);

        // Reset while a beat at idx 12 is pending
        start_dump();
        dump_ready = 1'b1;
        cyc = 0;
        while (!(valid_a && idx_a == AW'(12)) && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        dump_ready = 1'b0;
        check("pre_rst_idx", XLEN'(idx_a), 12);
        check("pre_rst_valid", XLEN'(valid_a), 1);
        #1;
        rst = 1'b1;
        #1;
        check("rst_valid", XLEN'(valid_a), 0);
        check("rst_busy", XLEN'(busy_a), 0);
        check("rst_idx", XLEN'(idx_a), 0);
        check("rst_data", ddata_a, 0);
        read_all_zero("midrst");
        @(negedge clk);
        rst = 1'b0;
        clear_models();
        @(posedge clk); #1;
        push_snapshot();
        start_dump();
        run_dump(0, 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
